totd_deconv_ctrl: RTL and testbench
===================================

Name: totd_deconv_ctrl

Overview:
- Sequencer and configuration controller for the three per-PMT compatibility ToTd deconvolution pipelines in sde_trigger.
- Generates the shared 40 MHz phase, ENABLE40[1:0], on the 120 MHz clock.
- Owns the live FD and FN constants for each channel and applies CPU register writes only at safe pipeline boundaries.
- Tracks pipeline refill after any config change, reset or phase slip, and tells the trigger logic when each channel's deconvolved output is valid.

Parameters:
- FD_BITS, 6: width of fractional decay constant (.yyyyyy).
- FN_BITS, 6: width of normalizer (xx.yyyy).
- PIPE_DEPTH, 6: enabled-edge latency from ADC input to the deconvolution output.
- FD_DEFAULT, 6'd59: FD value loaded at reset.
- FN_DEFAULT, 6'd20: FN value loaded at reset.

Ports:
- CLK  in  1  120 MHz clock.
- RSTN  in  1  asynchronous active-low reset.
- SYNC40  in  1  one-cycle pulse marking the CLK cycle that must be phase 0.
- CFG_WR  in  1  one-cycle write strobe.
- CFG_CHAN  in  2  target channel 0..2; value 3 is ignored.
- CFG_FD  in  FD_BITS  requested decay constant.
- CFG_FN  in  FN_BITS  requested normalizer.
- ERR_CLR  in  1  clears SYNC_ERR.
- ENABLE40  out  2  phase counter 0,1,2; the datapath advances when it is 0.
- FD0/FD1/FD2  out  FD_BITS each  live decay constant per channel.
- FN0/FN1/FN2  out  FN_BITS each  live normalizer per channel.
- CFG_PEND  out  3  per-channel write pending.
- CFG_ACK  out  3  one-cycle pulse when a channel's pending write is applied.
- VALID  out  3  the channel's deconvolved output reflects only the current config.
- SYNC_ERR  out  1  sticky flag: SYNC40 arrived out of phase.

Behaviour:
Reset (RSTN low, asynchronous):
- ENABLE40=0.
- FDn=FD_DEFAULT, FNn=FN_DEFAULT.
- CFG_PEND=0, CFG_ACK=0, VALID=0, SYNC_ERR=0.
- All flush counters = PIPE_DEPTH; all pending slots cleared.
- Release is synchronous to CLK.

Phase counter:
- ENABLE40 sequence 0→1→2→0.
- SYNC40 high forces the next value to 0.
- SYNC40 while ENABLE40==2 is aligned: no side effects.
- SYNC40 at any other phase is a slip:
  - sets SYNC_ERR;
  - reloads every flush counter to PIPE_DEPTH;
  - clears VALID for all channels on the next edge.
- ERR_CLR clears SYNC_ERR. If ERR_CLR and a slip occur in the same cycle, set wins.

Pending slots (one per channel):
- CFG_WR with CFG_CHAN<3 registers FD/FN into that channel's slot and sets CFG_PEND[chan] on the next edge.
- A second write to a channel that is already pending overwrites the slot (last wins). Only one ACK is issued.
- CFG_CHAN==3: no effect.

Apply:
- The apply cycle is any cycle with ENABLE40==2 and no SYNC40.
- On the closing edge of that cycle, every channel whose CFG_PEND is set, as sampled in that cycle:
  - copies its slot to FDn/FNn;
  - pulses CFG_ACK[n] for one cycle;
  - clears CFG_PEND[n];
  - reloads its flush counter to PIPE_DEPTH;
  - drops VALID[n].
- Live FD/FN therefore change only on the edge entering phase 0, so the next enabled edge sees consistent constants.
- A CFG_WR in the apply cycle is not applied that window:
  - if the channel was already pending, the old slot is applied and acked, and the new write becomes pending;
  - otherwise the write becomes pending for the next window.
- A slip cycle is not an apply cycle. Pending slots wait for the next ENABLE40==2 without SYNC40.

Flush and VALID:
- On each edge where ENABLE40==0, every nonzero flush counter decrements.
- VALID[n] is 1 exactly when flush[n]==0, registered.
- After reset, the first VALID rises PIPE_DEPTH enabled edges after RSTN deasserts, i.e. at the 3*PIPE_DEPTH-th CLK edge when SYNC40 stays low.
- A reload and a decrement in the same cycle: the reload wins.

Arithmetic:
- Flush counters are clog2(PIPE_DEPTH+1) bits and saturate at 0.
- No wrap-around on any counter except the phase counter.

Test Plan:
1. Reset release, SYNC40 low → ENABLE40 runs 0,1,2,0…; FD0..2=59, FN0..2=20; VALID=000 until the 18th edge, then 111.
2. After VALID=111, CFG_WR chan=1 FD=50 FN=24 with ENABLE40=0 → CFG_PEND=010 for 2 cycles. Then at the edge entering phase 0: FD1=50, FN1=24, CFG_ACK=010 for one cycle, VALID=101. VALID returns to 111 after 6 further enabled edges. Channels 0 and 2 stay untouched.
3. Writes to chan 0 (FD=40) then chan 0 (FD=45) then chan 2 in consecutive cycles, none in an apply cycle → a single apply edge gives FD0=45, FD2 updated, CFG_ACK=101 once.
4. CFG_WR chan 0 FD=30 while chan 0 is pending with FD=45, the write landing in the ENABLE40==2 cycle → FD0=45 applied and acked; FD0=30 pending and applied 3 cycles later with a second ACK.
5. SYNC40 pulse at ENABLE40==1 → ENABLE40=0 next cycle, SYNC_ERR=1, VALID=000, pending writes held. SYNC40 at ENABLE40==2 → no error, VALID unchanged. ERR_CLR → SYNC_ERR=0.
6. RSTN asserted mid-flush with chan 1 pending → all outputs return to reset values immediately, CFG_PEND=000, and no ACK is ever issued for the dropped write.

Source files
------------

// File: rtl/totd_deconv_ctrl.sv
// Sequencer/config controller for the three ToTd deconvolution pipelines:
// 40 MHz phase generation, safe-boundary constant updates and refill tracking.
//
// state | meaning
// PH0   | ENABLE40==0, datapath advances on the closing edge
// PH1   | ENABLE40==1, idle phase
// PH2   | ENABLE40==2, apply window when SYNC40 is low
module totd_deconv_ctrl #(
    parameter int                 FD_BITS    = 6,
    parameter int                 FN_BITS    = 6,
    parameter int                 PIPE_DEPTH = 6,
    parameter logic [FD_BITS-1:0] FD_DEFAULT = 6'd59,
    parameter logic [FN_BITS-1:0] FN_DEFAULT = 6'd20
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               SYNC40,
    input  logic               CFG_WR,
    input  logic [1:0]         CFG_CHAN,
    input  logic [FD_BITS-1:0] CFG_FD,
    input  logic [FN_BITS-1:0] CFG_FN,
    input  logic               ERR_CLR,
    output logic [1:0]         ENABLE40,
    output logic [FD_BITS-1:0] FD0,
    output logic [FD_BITS-1:0] FD1,
    output logic [FD_BITS-1:0] FD2,
    output logic [FN_BITS-1:0] FN0,
    output logic [FN_BITS-1:0] FN1,
    output logic [FN_BITS-1:0] FN2,
    output logic [2:0]         CFG_PEND,
    output logic [2:0]         CFG_ACK,
    output logic [2:0]         VALID,
    output logic               SYNC_ERR
);

    localparam int FL_BITS = $clog2(PIPE_DEPTH + 1);
    localparam logic [FL_BITS-1:0] FL_RELOAD = FL_BITS'(PIPE_DEPTH);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    phase_t phase, phase_nxt;
    logic   slip, apply;

    logic [1:0]         rst_pipe;
    logic               rst_sync_n;
    logic [2:0]         wr_hit, take;
    logic [2:0]         pend, ack, valid;
    logic               sync_err;
    logic [FD_BITS-1:0] fd_live [3];
    logic [FN_BITS-1:0] fn_live [3];
    logic [FD_BITS-1:0] slot_fd [3];
    logic [FN_BITS-1:0] slot_fn [3];
    logic [FL_BITS-1:0] flush     [3];
    logic [FL_BITS-1:0] flush_nxt [3];

    // Asserts immediately with RSTN; releases on the second CLK edge after RSTN rises.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_pipe[1];

    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            phase <= PH0;
        end else begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        phase_nxt = PH0;
        slip      = 1'b0;
        apply     = 1'b0;
        case (phase)
            PH0: phase_nxt = PH1;
            PH1: phase_nxt = PH2;
            PH2: phase_nxt = PH0;
            default: phase_nxt = PH0;
        endcase
        if (SYNC40) begin
            phase_nxt = PH0;
            slip      = (phase != PH2);
        end
        apply = (phase == PH2) && !SYNC40;
    end

    always_comb begin
        wr_hit = 3'b000;
        take   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            wr_hit[i]    = CFG_WR && (CFG_CHAN == 2'(i));
            take[i]      = apply && pend[i];
            flush_nxt[i] = flush[i];
            // Reload has priority over the enabled-edge decrement.
            if (slip || take[i]) begin
                flush_nxt[i] = FL_RELOAD;
            end else if ((phase == PH0) && (flush[i] != '0)) begin
                flush_nxt[i] = flush[i] - FL_BITS'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pend     <= 3'b000;
            ack      <= 3'b000;
            valid    <= 3'b000;
            sync_err <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                fd_live[i] <= FD_DEFAULT;
                fn_live[i] <= FN_DEFAULT;
                slot_fd[i] <= '0;
                slot_fn[i] <= '0;
                flush[i]   <= FL_RELOAD;
            end
        end else begin
            ack <= take;
            if (slip) begin
                sync_err <= 1'b1;
            end else if (ERR_CLR) begin
                sync_err <= 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                flush[i] <= flush_nxt[i];
                valid[i] <= (flush_nxt[i] == '0);
                if (take[i]) begin
                    fd_live[i] <= slot_fd[i];
                    fn_live[i] <= slot_fn[i];
                end
                // A write landing in the apply cycle refills the slot after the old value is taken.
                if (wr_hit[i]) begin
                    slot_fd[i] <= CFG_FD;
                    slot_fn[i] <= CFG_FN;
                    pend[i]    <= 1'b1;
                end else if (take[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    assign ENABLE40 = phase;
    assign FD0      = fd_live[0];
    assign FD1      = fd_live[1];
    assign FD2      = fd_live[2];
    assign FN0      = fn_live[0];
    assign FN1      = fn_live[1];
    assign FN2      = fn_live[2];
    assign CFG_PEND = pend;
    assign CFG_ACK  = ack;
    assign VALID    = valid;
    assign SYNC_ERR = sync_err;

endmodule

// File: tb/tb_totd_deconv_ctrl.sv
// Directed bench for totd_deconv_ctrl: boot refill, config apply windows,
// phase slips and mid-flush reset, all against hand-computed values.
module tb_totd_deconv_ctrl;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       SYNC40 = 1'b0;
    logic       CFG_WR = 1'b0;
    logic [1:0] CFG_CHAN = 2'd0;
    logic [5:0] CFG_FD = 6'd0;
    logic [5:0] CFG_FN = 6'd0;
    logic       ERR_CLR = 1'b0;
    logic [1:0] ENABLE40;
    logic [5:0] FD0, FD1, FD2, FN0, FN1, FN2;
    logic [2:0] CFG_PEND, CFG_ACK, VALID;
    logic       SYNC_ERR;

    int n_chk = 0;
    int n_bad = 0;
    int ph = 0;
    int rst_cnt = 0;

    totd_deconv_ctrl dut (
        .CLK(CLK), .RSTN(RSTN), .SYNC40(SYNC40), .CFG_WR(CFG_WR),
        .CFG_CHAN(CFG_CHAN), .CFG_FD(CFG_FD), .CFG_FN(CFG_FN), .ERR_CLR(ERR_CLR),
        .ENABLE40(ENABLE40), .FD0(FD0), .FD1(FD1), .FD2(FD2),
        .FN0(FN0), .FN1(FN1), .FN2(FN2), .CFG_PEND(CFG_PEND),
        .CFG_ACK(CFG_ACK), .VALID(VALID), .SYNC_ERR(SYNC_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One CLK edge; the expected phase includes the two-edge reset release.
    task automatic step();
        @(posedge CLK);
        if (!RSTN) begin
            rst_cnt = 0;
            ph = 0;
        end else if (rst_cnt < 2) begin
            rst_cnt++;
        end else begin
            ph = (SYNC40 || ph == 2) ? 0 : ph + 1;
        end
        #1;
        chk("phase", 32'(ENABLE40), 32'(ph));
    endtask

    task automatic wr(input logic [1:0] ch, input logic [5:0] fd, input logic [5:0] fn);
        CFG_WR = 1'b1;
        CFG_CHAN = ch;
        CFG_FD = fd;
        CFG_FN = fn;
        step();
        CFG_WR = 1'b0;
    endtask

    task automatic go_to(input int p);
        for (int i = 0; i < 3 && ph != p; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        chk("rst_en40", 32'(ENABLE40), 0);
        chk("rst_fd0", 32'(FD0), 59);
        chk("rst_fn2", 32'(FN2), 20);
        chk("rst_valid", 32'(VALID), 0);
        chk("rst_pend", 32'(CFG_PEND), 0);
        chk("rst_ack", 32'(CFG_ACK), 0);
        chk("rst_err", 32'(SYNC_ERR), 0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;

        for (int k = 1; k <= 18; k++) begin
            step();
            chk("valid_boot", 32'(VALID), (k >= 18) ? 32'd7 : 32'd0);
        end
        chk("boot_fd1", 32'(FD1), 59);
        chk("boot_fn1", 32'(FN1), 20);

        // Single write to channel 1 in phase 0.
        go_to(0);
        wr(2'd1, 6'd50, 6'd24);
        chk("t2_pend_a", 32'(CFG_PEND), 2);
        step();
        chk("t2_pend_b", 32'(CFG_PEND), 2);
        chk("t2_fd1_old", 32'(FD1), 59);
        step();
        chk("t2_fd1", 32'(FD1), 50);
        chk("t2_fn1", 32'(FN1), 24);
        chk("t2_ack", 32'(CFG_ACK), 2);
        chk("t2_valid", 32'(VALID), 5);
        chk("t2_pend_c", 32'(CFG_PEND), 0);
        chk("t2_fd0", 32'(FD0), 59);
        chk("t2_fd2", 32'(FD2), 59);
        chk("t2_fn2", 32'(FN2), 20);
        step();
        chk("t2_ack_off", 32'(CFG_ACK), 0);
        for (int k = 0; k < 14; k++) step();
        chk("t2_valid_e15", 32'(VALID), 5);
        step();
        chk("t2_valid_e16", 32'(VALID), 7);

        // Burst: ch0 in apply cycle (deferred), ch0 overwrite, ch2.
        go_to(2);
        wr(2'd0, 6'd40, 6'd10);
        chk("t3_pend_a", 32'(CFG_PEND), 1);
        chk("t3_noack", 32'(CFG_ACK), 0);
        chk("t3_fd0_old", 32'(FD0), 59);
        wr(2'd0, 6'd45, 6'd11);
        chk("t3_pend_b", 32'(CFG_PEND), 1);
        wr(2'd2, 6'd33, 6'd12);
        chk("t3_pend_c", 32'(CFG_PEND), 5);
        step();
        chk("t3_fd0", 32'(FD0), 45);
        chk("t3_fn0", 32'(FN0), 11);
        chk("t3_fd2", 32'(FD2), 33);
        chk("t3_fn2", 32'(FN2), 12);
        chk("t3_ack", 32'(CFG_ACK), 5);
        chk("t3_pend_d", 32'(CFG_PEND), 0);
        chk("t3_fd1", 32'(FD1), 50);
        step();
        chk("t3_ack_off", 32'(CFG_ACK), 0);

        // Write in apply cycle while the channel is already pending.
        go_to(0);
        wr(2'd0, 6'd45, 6'd13);
        step();
        wr(2'd0, 6'd30, 6'd14);
        chk("t4_fd0_a", 32'(FD0), 45);
        chk("t4_fn0_a", 32'(FN0), 13);
        chk("t4_ack_a", 32'(CFG_ACK), 1);
        chk("t4_pend_a", 32'(CFG_PEND), 1);
        step();
        chk("t4_ack_off", 32'(CFG_ACK), 0);
        chk("t4_fd0_hold", 32'(FD0), 45);
        step();
        step();
        chk("t4_fd0_b", 32'(FD0), 30);
        chk("t4_fn0_b", 32'(FN0), 14);
        chk("t4_ack_b", 32'(CFG_ACK), 1);
        chk("t4_pend_b", 32'(CFG_PEND), 0);

        // Channel 3 writes are ignored.
        wr(2'd3, 6'd1, 6'd1);
        chk("c3_pend", 32'(CFG_PEND), 0);
        step();
        step();
        chk("c3_ack", 32'(CFG_ACK), 0);
        chk("c3_fd0", 32'(FD0), 30);
        chk("c3_fd1", 32'(FD1), 50);
        chk("c3_fd2", 32'(FD2), 33);

        // Phase slip with a pending write, then aligned SYNC40, then ERR_CLR.
        chk("t5_valid_pre", 32'(VALID), 2);
        wr(2'd2, 6'd20, 6'd5);
        chk("t5_pend", 32'(CFG_PEND), 4);
        SYNC40 = 1'b1;
        step();
        SYNC40 = 1'b0;
        chk("t5_err", 32'(SYNC_ERR), 1);
        chk("t5_valid", 32'(VALID), 0);
        chk("t5_pend_held", 32'(CFG_PEND), 4);
        chk("t5_fd2_held", 32'(FD2), 33);
        chk("t5_ack", 32'(CFG_ACK), 0);
        step();
        step();
        SYNC40 = 1'b1;
        step();
        SYNC40 = 1'b0;
        chk("t5_align_err", 32'(SYNC_ERR), 1);
        chk("t5_align_pend", 32'(CFG_PEND), 4);
        chk("t5_align_ack", 32'(CFG_ACK), 0);
        chk("t5_align_valid", 32'(VALID), 0);
        step();
        step();
        step();
        chk("t5_fd2", 32'(FD2), 20);
        chk("t5_fn2", 32'(FN2), 5);
        chk("t5_ack_apply", 32'(CFG_ACK), 4);
        chk("t5_pend_clr", 32'(CFG_PEND), 0);
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        chk("t5_errclr", 32'(SYNC_ERR), 0);
        SYNC40 = 1'b1;
        ERR_CLR = 1'b1;
        step();
        SYNC40 = 1'b0;
        ERR_CLR = 1'b0;
        chk("t5_setwins", 32'(SYNC_ERR), 1);
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        chk("t5_errclr2", 32'(SYNC_ERR), 0);

        // Reset mid-flush with channel 1 pending.
        go_to(0);
        wr(2'd1, 6'd7, 6'd3);
        chk("t6_pend", 32'(CFG_PEND), 2);
        #2;
        RSTN = 1'b0;
        #1;
        chk("t6_en40", 32'(ENABLE40), 0);
        chk("t6_fd1", 32'(FD1), 59);
        chk("t6_fn1", 32'(FN1), 20);
        chk("t6_fd0", 32'(FD0), 59);
        chk("t6_fd2", 32'(FD2), 59);
        chk("t6_pend_rst", 32'(CFG_PEND), 0);
        chk("t6_valid", 32'(VALID), 0);
        chk("t6_ack", 32'(CFG_ACK), 0);
        step();
        step();
        RSTN = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t6_no_ack", 32'(CFG_ACK), 0);
            chk("t6_no_pend", 32'(CFG_PEND), 0);
            chk("t6_fd1_def", 32'(FD1), 59);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
